// File: rtl/model_draw_sequencer_pkg.sv
// Shared types for the draw sequencer: triangle payload, draw command and
// tagged triangle groupings used by the integrating level.
package model_draw_sequencer_pkg;

  localparam int MAX_MODEL_COUNT_DEF    = 10;
  localparam int MAX_TRIANGLE_COUNT_DEF = 512;
  localparam int INSTANCE_ID_WIDTH_DEF  = 8;
  localparam int MIDX_W_DEF             = $clog2(MAX_MODEL_COUNT_DEF);
  localparam int TIDX_W_DEF             = $clog2(MAX_TRIANGLE_COUNT_DEF + 1);

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic [MIDX_W_DEF-1:0]            model_index;
    logic [INSTANCE_ID_WIDTH_DEF-1:0] instance_id;
  } draw_cmd_t;

  typedef struct packed {
    triangle_t                        triangle;
    logic [INSTANCE_ID_WIDTH_DEF-1:0] instance_id;
    logic                             first;
    logic                             last;
  } tagged_triangle_t;

endpackage

// File: rtl/model_draw_sequencer.sv
// Walks the model buffer read port for each draw command, one read in flight,
// and forwards tagged triangles plus a per-command completion pulse.
module model_draw_sequencer
  import model_draw_sequencer_pkg::*;
#(
  parameter int MAX_MODEL_COUNT    = MAX_MODEL_COUNT_DEF,
  parameter int MAX_TRIANGLE_COUNT = MAX_TRIANGLE_COUNT_DEF,
  parameter int INSTANCE_ID_WIDTH  = INSTANCE_ID_WIDTH_DEF,
  localparam int MIDX_W = $clog2(MAX_MODEL_COUNT),
  localparam int TIDX_W = $clog2(MAX_TRIANGLE_COUNT + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [MIDX_W-1:0]            cmd_model_index,
  input  logic [INSTANCE_ID_WIDTH-1:0] cmd_instance_id,
  output logic                         mb_req_valid,
  input  logic                         mb_req_ready,
  output logic [MIDX_W-1:0]            mb_req_model_index,
  output logic [TIDX_W-1:0]            mb_req_triangle_index,
  input  logic                         mb_rsp_valid,
  output logic                         mb_rsp_ready,
  input  triangle_t                    mb_rsp_data,
  input  logic                         mb_rsp_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output triangle_t                    out_triangle,
  output logic [INSTANCE_ID_WIDTH-1:0] out_instance_id,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         done_valid,
  output logic [TIDX_W-1:0]            done_count,
  output logic                         done_empty
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]                   state_r;
  logic [1:0]                   state_s;
  logic [MIDX_W-1:0]            model_r;
  logic [INSTANCE_ID_WIDTH-1:0] inst_r;
  logic [TIDX_W-1:0]            tri_idx_r;
  logic [TIDX_W-1:0]            count_r;
  logic                         wait_first_r;
  logic                         done_valid_r;
  logic [TIDX_W-1:0]            done_count_r;
  logic                         done_empty_r;

  logic in_wait_s;
  logic rsp_live_s;
  logic last_s;
  logic out_hs_s;
  logic no_rsp_s;
  logic cmd_hs_s;

  assign in_wait_s  = (state_r == ST_WAIT);
  assign rsp_live_s = in_wait_s && mb_rsp_valid;
  // The final slot of the buffer always terminates the walk, so tri_idx never wraps.
  assign last_s     = mb_rsp_last || (tri_idx_r == TIDX_W'(MAX_TRIANGLE_COUNT - 1));
  assign out_hs_s   = rsp_live_s && out_ready;
  assign no_rsp_s   = in_wait_s && wait_first_r && !mb_rsp_valid;
  // Holding off during the done pulse keeps completion and the next accept in separate cycles.
  assign cmd_ready  = (state_r == ST_IDLE) && !done_valid_r;
  assign cmd_hs_s   = cmd_valid && cmd_ready;

  assign mb_req_valid          = (state_r == ST_REQ);
  assign mb_req_model_index    = model_r;
  assign mb_req_triangle_index = tri_idx_r;
  assign mb_rsp_ready          = in_wait_s && out_ready;

  assign out_valid       = rsp_live_s;
  assign out_triangle    = mb_rsp_data;
  assign out_instance_id = inst_r;
  assign out_first       = rsp_live_s && (tri_idx_r == TIDX_W'(0));
  assign out_last        = rsp_live_s && last_s;

  assign done_valid = done_valid_r;
  assign done_count = done_count_r;
  assign done_empty = done_empty_r;

  // Next-state selection for the IDLE/REQ/WAIT walk.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s) state_s = ST_REQ;
        else          state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mb_req_ready) state_s = ST_WAIT;
        else              state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (no_rsp_s)      state_s = ST_IDLE;
        else if (out_hs_s) state_s = last_s ? ST_IDLE : ST_REQ;
        else               state_s = ST_WAIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, command latch, walk counters and completion report.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      model_r      <= MIDX_W'(0);
      inst_r       <= INSTANCE_ID_WIDTH'(0);
      tri_idx_r    <= TIDX_W'(0);
      count_r      <= TIDX_W'(0);
      wait_first_r <= 1'b0;
      done_valid_r <= 1'b0;
      done_count_r <= TIDX_W'(0);
      done_empty_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_first_r <= (state_r == ST_REQ) && mb_req_ready;
      done_valid_r <= 1'b0;
      if (cmd_hs_s) begin
        model_r   <= cmd_model_index;
        inst_r    <= cmd_instance_id;
        tri_idx_r <= TIDX_W'(0);
        count_r   <= TIDX_W'(0);
      end
      // Buffer latency is one cycle, so silence in the first WAIT cycle means the walk ran off the model.
      if (no_rsp_s) begin
        done_valid_r <= 1'b1;
        done_count_r <= count_r;
        done_empty_r <= (count_r == TIDX_W'(0));
      end
      if (out_hs_s) begin
        count_r <= count_r + TIDX_W'(1);
        if (last_s) begin
          done_valid_r <= 1'b1;
          done_count_r <= count_r + TIDX_W'(1);
          done_empty_r <= 1'b0;
        end else begin
          tri_idx_r <= tri_idx_r + TIDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_model_draw_sequencer.sv
// Self-checking bench: behavioural model buffer, table-driven commands,
// hand sequences for stalls/back-to-back/reset, and randomized commands.
module tb_model_draw_sequencer;
  import model_draw_sequencer_pkg::*;

  localparam int MMC = 10;
  localparam int MTC = 8;
  localparam int IW  = 8;
  localparam int MW  = $clog2(MMC);
  localparam int TW  = $clog2(MTC + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [MW-1:0] cmd_model_index;
  logic [IW-1:0] cmd_instance_id;
  logic          mb_req_valid;
  logic          mb_req_ready;
  logic [MW-1:0] mb_req_model_index;
  logic [TW-1:0] mb_req_triangle_index;
  logic          mb_rsp_valid;
  logic          mb_rsp_ready;
  triangle_t     mb_rsp_data;
  logic          mb_rsp_last;
  logic          out_valid;
  logic          out_ready;
  triangle_t     out_triangle;
  logic [IW-1:0] out_instance_id;
  logic          out_first;
  logic          out_last;
  logic          done_valid;
  logic [TW-1:0] done_count;
  logic          done_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sizes[MMC];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  model_draw_sequencer #(
    .MAX_MODEL_COUNT(MMC), .MAX_TRIANGLE_COUNT(MTC), .INSTANCE_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_model_index(cmd_model_index), .cmd_instance_id(cmd_instance_id),
    .mb_req_valid(mb_req_valid), .mb_req_ready(mb_req_ready),
    .mb_req_model_index(mb_req_model_index), .mb_req_triangle_index(mb_req_triangle_index),
    .mb_rsp_valid(mb_rsp_valid), .mb_rsp_ready(mb_rsp_ready),
    .mb_rsp_data(mb_rsp_data), .mb_rsp_last(mb_rsp_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_triangle(out_triangle),
    .out_instance_id(out_instance_id), .out_first(out_first), .out_last(out_last),
    .done_valid(done_valid), .done_count(done_count), .done_empty(done_empty)
  );

  function automatic int bm_size(input int m);
    if (m < MMC) return sizes[m];
    return 0;
  endfunction

  // Reference: a command yields min(model size, capacity) triangles.
  function automatic int exp_n(input int m);
    int s;
    s = bm_size(m);
    return (s < MTC) ? s : MTC;
  endfunction

  function automatic triangle_t tri_data(input int m, input int i);
    logic [143:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      v[k*32 +: 32] = (m * 32'h0100_0193) ^ (i * 32'h9E37_79B9) ^ (k * 32'h0001_0001) ^ 32'h5A5A_0F0F;
    v[143:128] = 16'(m * 64 + i);
    return triangle_t'(v);
  endfunction

  // Behavioural model buffer: one-cycle latency, response held until consumed.
  logic      bm_valid;
  triangle_t bm_data;
  logic      bm_last;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bm_valid <= 1'b0;
      bm_data  <= '0;
      bm_last  <= 1'b0;
    end else if (mb_req_valid && mb_req_ready) begin
      if (int'(mb_req_triangle_index) < bm_size(int'(mb_req_model_index))) begin
        bm_valid <= 1'b1;
        bm_data  <= tri_data(int'(mb_req_model_index), int'(mb_req_triangle_index));
        bm_last  <= (int'(mb_req_triangle_index) == bm_size(int'(mb_req_model_index)) - 1);
      end else begin
        bm_valid <= 1'b0;
      end
    end else if (bm_valid && mb_rsp_ready) begin
      bm_valid <= 1'b0;
    end
  end
  assign mb_rsp_valid = bm_valid;
  assign mb_rsp_data  = bm_data;
  assign mb_rsp_last  = bm_last;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input int m, input int inst, input int stall_beat, input int stall_len,
                         input int req_stall, input bit rand_mode, input bit chain,
                         input int nm, input int ninst,
                         output int acc_cyc, output int done_cyc, output int last_req_cyc,
                         output int d_count, output bit d_empty);
    int n, b, rs_cnt, st_cnt, nreq;
    bit accepted, cleared, got_done;
    triangle_t et;
    n = exp_n(m); b = 0; rs_cnt = 0; st_cnt = 0; nreq = 0;
    accepted = 1'b0; cleared = 1'b0; got_done = 1'b0;
    acc_cyc = -1; done_cyc = -1; last_req_cyc = -1; d_count = -1; d_empty = 1'b0;
    for (int t = 0; t < 400 && !got_done; t++) begin
      @(negedge clk);
      if (!accepted) begin
        cmd_valid = 1'b1; cmd_model_index = MW'(m); cmd_instance_id = IW'(inst);
      end else if (!cleared) begin
        cleared = 1'b1;
        if (chain) begin cmd_model_index = MW'(nm); cmd_instance_id = IW'(ninst); end
        else cmd_valid = 1'b0;
      end
      if (rand_mode) begin
        out_ready    = 1'($urandom_range(0, 1));
        mb_req_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready    = !(b == stall_beat && st_cnt < stall_len);
        mb_req_ready = !(nreq == 0 && rs_cnt < req_stall);
      end
      #1;
      if (accepted) check("cmd_ready_busy", 160'(cmd_ready), 160'(0));
      else if (cmd_ready) begin accepted = 1'b1; acc_cyc = cyc; end
      if (mb_req_valid) begin
        check("req_fields", 160'({mb_req_model_index, mb_req_triangle_index}), 160'({MW'(m), TW'(b)}));
        if (mb_req_ready) begin nreq++; last_req_cyc = cyc; end
        else if (nreq == 0) rs_cnt++;
      end
      if (out_valid) begin
        if (b >= n) begin
          check("extra_beat", 160'(b), 160'(n - 1));
        end else begin
          et = tri_data(m, b);
          check("beat", {6'd0, out_triangle, out_instance_id, out_first, out_last},
                {6'd0, et, IW'(inst), b == 0, b == n - 1});
          if (out_ready) b++;
          else begin
            check("stall_quiet", 160'({mb_req_valid, done_valid}), 160'(0));
            if (b == stall_beat) st_cnt++;
          end
        end
      end
      if (done_valid) begin
        got_done = 1'b1; done_cyc = cyc; d_count = int'(done_count); d_empty = done_empty;
        check("beats_at_done", 160'(b), 160'(n));
      end
    end
    if (!got_done) check("done_timeout", 160'(0), 160'(1));
    if (!chain) begin
      @(negedge clk);
      out_ready = 1'b1; mb_req_ready = 1'b1;
      #1;
      check("ready_after_done", 160'(cmd_ready), 160'(1));
    end
  endtask

  typedef struct {
    int m; int inst; int stall_beat; int stall_len; int req_stall;
    int exp_count; bit exp_empty; int lat_mode; int lat;
  } vec_t;

  vec_t vecs[9];
  int acc_c, done_c, lreq_c, dc, acc2, done2, lreq2, dc2, k, seen, m, n;
  bit de, de2;

  initial begin
    sizes = '{4, 2, 3, 1, 5, 0, 5, 8, 7, 12};
    vecs[0] = '{2, 8'h15, -1, 0, 0, 3, 1'b0, 1, 7};
    vecs[1] = '{5, 8'h22, -1, 0, 0, 0, 1'b1, 2, 2};
    vecs[2] = '{0, 8'h33, 1, 5, 0, 4, 1'b0, 0, 0};
    vecs[3] = '{0, 8'h55, -1, 0, 3, 4, 1'b0, 0, 0};
    vecs[4] = '{7, 8'h66, -1, 0, 0, 8, 1'b0, 0, 0};
    vecs[5] = '{9, 8'h67, -1, 0, 0, 8, 1'b0, 0, 0};
    vecs[6] = '{12, 8'h68, -1, 0, 0, 0, 1'b1, 2, 2};
    vecs[7] = '{4, 8'h69, -1, 0, 0, 5, 1'b0, 1, 11};
    vecs[8] = '{8, 8'h6A, 2, 2, 1, 7, 1'b0, 0, 0};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_model_index = '0; cmd_instance_id = '0;
    out_ready = 1'b0; mb_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          160'({cmd_ready, mb_req_valid, mb_rsp_ready, out_valid, out_first, out_last, done_valid, done_count, done_empty}),
          160'({1'b1, 6'b0, TW'(0), 1'b0}));
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].m, vecs[i].inst, vecs[i].stall_beat, vecs[i].stall_len, vecs[i].req_stall,
              1'b0, 1'b0, 0, 0, acc_c, done_c, lreq_c, dc, de);
      check($sformatf("vec%0d_done", i), 160'({dc, de}), 160'({vecs[i].exp_count, vecs[i].exp_empty}));
      if (vecs[i].lat_mode == 1) check($sformatf("vec%0d_lat", i), 160'(done_c - acc_c), 160'(vecs[i].lat));
      if (vecs[i].lat_mode == 2) check($sformatf("vec%0d_lat", i), 160'(done_c - lreq_c), 160'(vecs[i].lat));
    end

    // Back-to-back commands offered continuously.
    run_cmd(1, 8'h61, -1, 0, 0, 1'b0, 1'b1, 3, 8'h62, acc_c, done_c, lreq_c, dc, de);
    run_cmd(3, 8'h62, -1, 0, 0, 1'b0, 1'b0, 0, 0, acc2, done2, lreq2, dc2, de2);
    check("b2b_first", 160'({dc, de}), 160'({32'd2, 1'b0}));
    check("b2b_second", 160'({dc2, de2}), 160'({32'd1, 1'b0}));
    check("b2b_accept_gap", 160'(acc2 - done_c), 160'(1));

    // Reset during WAIT of a 5-triangle draw.
    k = 0; seen = 0;
    for (int t = 0; t < 60 && seen < 2; t++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_model_index = MW'(4); cmd_instance_id = IW'(8'h77);
      out_ready = 1'b1; mb_req_ready = 1'b1;
      #1;
      if (cmd_valid && cmd_ready) k = 1;
      if (out_valid) seen++;
    end
    check("reset_reach_wait", 160'(seen), 160'(2));
    rstn = 1'b0;
    #1;
    check("midreset_outputs",
          160'({cmd_ready, mb_req_valid, mb_rsp_ready, out_valid, out_first, out_last, done_valid, done_count, done_empty}),
          160'({1'b1, 6'b0, TW'(0), 1'b0}));
    cmd_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      check("post_reset_idle", 160'({done_valid, cmd_ready}), 160'({1'b0, 1'b1}));
    end
    run_cmd(2, 8'h88, -1, 0, 0, 1'b0, 1'b0, 0, 0, acc_c, done_c, lreq_c, dc, de);
    check("post_reset_cmd", 160'({dc, de}), 160'({32'd3, 1'b0}));

    // Randomized models, commands and handshakes against the reference.
    for (int i = 0; i < MMC; i++) sizes[i] = $urandom_range(0, 11);
    for (int r = 0; r < 25; r++) begin
      m = $urandom_range(0, 11);
      n = exp_n(m);
      run_cmd(m, $urandom_range(0, 255), -1, 0, 0, 1'b1, 1'b0, 0, 0, acc_c, done_c, lreq_c, dc, de);
      check($sformatf("rand%0d_done", r), 160'({dc, de}), 160'({n, n == 0}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
